// File: rtl/spi_ram_bridge.sv
// SPI-style serial bridge into a small single-port RAM.
// A frame is: rw bit, 2 cmd bits, PW payload bits, all MSB first, sampled on clk
// while ss_n is low. Commands: 00 write-address, 01 write-data, 10 read-address,
// 11 read-data (streams DATA_W bits out on miso, MSB first).
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   ss_n      - slave select, active low
//   mosi      - serial data in
//   miso      - serial data out (0 outside SEND)
//   busy      - high whenever the FSM is not IDLE
//   frame_err - sticky error, cleared when the next frame starts
module spi_ram_bridge #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned PW      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned FW      = PW + 2;
  localparam int unsigned CNT_MAX = (FW > DATA_W) ? FW : DATA_W;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, CHK, SHIFT, EXEC, SEND} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]       in_sr_q, in_sr_d;
  logic [DATA_W-1:0]   out_sr_q, out_sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic                miso_q, miso_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [DATA_W-1:0]   rd_word;
  logic [PW-1:0]       payload;
  logic [1:0]          cmd;
  logic                wr_ok, rd_ok;

  assign payload = in_sr_q[PW-1:0];
  assign cmd     = in_sr_q[FW-1:PW];
  assign wr_ok   = {1'b0, wr_ptr_q} < DEPTH_L;
  assign rd_ok   = {1'b0, rd_ptr_q} < DEPTH_L;
  assign rd_word = rd_ok ? mem[rd_ptr_q] : '0;

  // Pointer increment with wrap at DEPTH-1.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if ({1'b0, p} == DEPTH_L - (ADDR_W + 1)'(1)) return '0;
    return p + ADDR_W'(1);
  endfunction

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    in_sr_d  = in_sr_q;
    out_sr_d = out_sr_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    miso_d   = 1'b0;
    err_d    = err_q;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ss_n) begin
          state_d = CHK;
          err_d   = 1'b0;
        end
      end
      CHK: begin
        rw_d    = mosi;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        in_sr_d = {in_sr_q[FW-2:0], mosi};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(FW - 1)) state_d = EXEC;
      end
      EXEC: begin
        state_d = IDLE;
        if (rw_q != cmd[1]) begin
          err_d = 1'b1;
        end else begin
          case (cmd)
            2'b00: wr_ptr_d = payload[ADDR_W-1:0];
            2'b01: begin
              if (wr_ok) begin
                mem_we = 1'b1;
                if (AUTO_INC != 0) wr_ptr_d = ptr_inc(wr_ptr_q);
              end else begin
                err_d = 1'b1;
              end
            end
            2'b10: rd_ptr_d = payload[ADDR_W-1:0];
            default: begin
              // Out-of-range read streams zeros (rd_word is already forced to 0).
              if (!rd_ok) err_d = 1'b1;
              miso_d   = rd_word[DATA_W-1];
              out_sr_d = rd_word << 1;
              cnt_d    = '0;
              state_d  = SEND;
            end
          endcase
        end
      end
      SEND: begin
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = IDLE;
          if (AUTO_INC != 0 && rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
          miso_d   = out_sr_q[DATA_W-1];
          out_sr_d = out_sr_q << 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Deselect mid-frame discards all side effects of this cycle.
    if (state_q != IDLE && ss_n) begin
      state_d  = IDLE;
      miso_d   = 1'b0;
      mem_we   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      in_sr_q  <= '0;
      out_sr_q <= '0;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      in_sr_q  <= in_sr_d;
      out_sr_q <= out_sr_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      miso_q   <= miso_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Memory array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= payload[DATA_W-1:0];
  end

  assign miso      = miso_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge: frame tasks push expected read-data
// words (value, first-bit cycle, bit count); a monitor collects miso bits and
// compares. A second instance with DEPTH=200 shares the stimulus for the
// out-of-range write case.
module tb_spi_ram_bridge;

  logic clk, rst, ss_n, mosi;
  logic miso, busy, frame_err;
  logic miso2, busy2, ferr2;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int idle_viol = 0;

  typedef struct {
    logic [7:0] val;
    int         start;
    int         n;
  } exp_t;

  exp_t sb[$];

  spi_ram_bridge u_dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .busy(busy), .frame_err(frame_err)
  );

  spi_ram_bridge #(.DEPTH(200)) u_d200 (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi),
    .miso(miso2), .busy(busy2), .frame_err(ferr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    else n_pass++;
  endtask

  // One full frame. abort_bits >= 0 deselects after that many payload bits;
  // trunc_bits >= 0 pulses rst after that many SEND bits of a read-data frame.
  task automatic frame(input logic rw, input logic [1:0] cmd, input logic [7:0] pl,
                       input logic [7:0] exp_v, input int abort_bits, input int trunc_bits);
    logic [9:0] bits;
    int nb;
    exp_t it;
    bits = {cmd, pl};
    nb = (abort_bits < 0) ? 10 : 2 + abort_bits;
    @(posedge clk); #1; ss_n = 1'b0; mosi = 1'b0;
    @(posedge clk); #1; mosi = rw;
    chk("err_clr_at_start", frame_err, 0);
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1; mosi = bits[9-i];
    end
    @(posedge clk); #1;
    if (abort_bits >= 0) begin
      ss_n = 1'b1;
      chk("abort_busy_before", busy, 1);
      @(posedge clk); #1;
      chk("abort_busy_after", busy, 0);
      return;
    end
    // Now in the EXEC cycle.
    if (rw && cmd == 2'b11) begin
      it.val   = exp_v;
      it.start = cyc + 1;
      it.n     = (trunc_bits < 0) ? 8 : trunc_bits;
      sb.push_back(it);
      if (trunc_bits >= 0) begin
        repeat (1 + trunc_bits) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        chk("rst_send_miso", miso, 0);
        chk("rst_send_busy", busy, 0);
        chk("rst_send_err", frame_err, 0);
        ss_n = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        return;
      end
      repeat (9) @(posedge clk);
      #1;
    end else begin
      @(posedge clk); #1;
    end
    ss_n = 1'b1;
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic wa(input logic [7:0] a); frame(1'b0, 2'b00, a, 8'h00, -1, -1); endtask
  task automatic wd(input logic [7:0] d); frame(1'b0, 2'b01, d, 8'h00, -1, -1); endtask
  task automatic ra(input logic [7:0] a); frame(1'b1, 2'b10, a, 8'h00, -1, -1); endtask
  task automatic rd(input logic [7:0] e); frame(1'b1, 2'b11, 8'h00, e, -1, -1); endtask

  // Monitor: collects miso bits in each expected SEND window; miso must be 0 elsewhere.
  initial begin
    exp_t it;
    logic [7:0] got, mask;
    logic busy_ok;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && cyc == sb[0].start) begin
        it = sb.pop_front();
        got = 8'h00;
        busy_ok = 1'b1;
        for (int b = 0; b < it.n; b++) begin
          if (b > 0) @(negedge clk);
          got[7-b] = miso;
          if (busy !== 1'b1) busy_ok = 1'b0;
        end
        mask = 8'hFF << (8 - it.n);
        chk("miso_word", {24'h0, got}, {24'h0, it.val & mask});
        chk("busy_in_send", {31'h0, busy_ok}, 1);
      end else if (miso !== 1'b0) begin
        idle_viol++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

  initial begin
    ss_n = 1'b1; mosi = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_miso", miso, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic write/read with auto-increment.
    wa(8'h10); wd(8'hA5); wd(8'h3C); ra(8'h10); rd(8'hA5); rd(8'h3C);
    chk("err_basic", frame_err, 0);

    // Pointer wrap 0xFF -> 0x00.
    wa(8'hFF); wd(8'h11); wd(8'h22); ra(8'hFF); rd(8'h11); rd(8'h22);

    // rw/cmd mismatch: error, no action, rd_ptr unchanged.
    ra(8'h10);
    frame(1'b0, 2'b11, 8'h00, 8'h00, -1, -1);
    chk("mismatch_err", frame_err, 1);
    rd(8'hA5);
    chk("err_cleared_next", frame_err, 0);

    // Abort mid-payload leaves memory untouched.
    wa(8'h20); wd(8'h77); wa(8'h20);
    frame(1'b0, 2'b01, 8'hFF, 8'h00, 5, -1);
    ra(8'h20); rd(8'h77);

    // DEPTH=200 instance drops a write at 0xC8; full-depth instance accepts it.
    wa(8'hC8);
    chk("d200_err_after_wa", ferr2, 0);
    wd(8'h5A);
    chk("d200_oob_err", ferr2, 1);
    chk("d256_no_err", frame_err, 0);
    ra(8'hC8); rd(8'h5A);

    // Reset during SEND truncates output; next read uses rd_ptr = 0.
    ra(8'h10);
    frame(1'b1, 2'b11, 8'h00, 8'hA5, -1, 3);
    rd(8'h22);

    repeat (5) @(posedge clk);
    #1;
    chk("miso_idle_zero", idle_viol, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
